// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encoding and bit-period computation
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

   function automatic logic parity_bit(input logic [7:0] d, input logic sel);
      if (sel == PAR_EVEN) begin
         return ^d;
      end else if (sel == PAR_ODD) begin
         return ~(^d);
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and terminal-count flag
module uart_baud_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tc
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tc) begin
         cnt_d = '0;
      end
   end

   assign tc = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_parity.sv
// rtl/uart_tx_parity.sv - UART transmitter, 8 data bits + parity + 1 stop, one-byte holding register
module uart_tx_parity
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 24000000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       parity,
   input  logic       send,
   output logic       tdre,
   output logic       busy,
   output logic       tx
);

   localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

   tx_state_e  state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_par_q, hold_par_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] shift_q, shift_d;
   logic       par_bit_q, par_bit_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       tx_q, tx_d;
   logic       load;
   logic       baud_clr;
   logic       baud_tc;

   // Counter is held at zero while idle so every frame starts on a fresh bit period.
   assign baud_clr = (state_q == IDLE);

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .tc    (baud_tc)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_par_d  = hold_par_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      bit_cnt_d   = bit_cnt_q;
      tx_d        = tx_q;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            load = hold_full_q;
         end
         START: begin
            if (baud_tc) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
               tx_d      = shift_q[0];
            end
         end
         DATA: begin
            if (baud_tc) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = PAR;
                  tx_d    = par_bit_q;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         PAR: begin
            if (baud_tc) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (baud_tc) begin
               tx_d = 1'b1;
               if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Load only happens with the holding register full, so it never collides with an accepted send.
      if (load) begin
         state_d     = START;
         shift_d     = hold_q;
         par_bit_d   = parity_bit(hold_q, hold_par_q);
         bit_cnt_d   = 3'd0;
         tx_d        = 1'b0;
         hold_full_d = 1'b0;
      end

      if (send && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_d      = tx_data;
         hold_par_d  = parity;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= 8'h00;
         hold_par_q  <= 1'b0;
         hold_full_q <= 1'b0;
         shift_q     <= 8'h00;
         par_bit_q   <= 1'b0;
         bit_cnt_q   <= 3'd0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_par_q  <= hold_par_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         par_bit_q   <= par_bit_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
      end
   end

   assign tdre = ~hold_full_q;
   assign busy = (state_q != IDLE);
   assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// tb/tb_uart_tx_parity.sv - self-checking bench for uart_tx_parity with line model and reference receiver
module tb_uart_tx_parity;

   localparam int DIV        = 4;
   localparam int FRAME_CLKS = 11 * DIV;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       send    = 1'b0;
   logic       parity  = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tdre;
   logic       busy;
   logic       tx;

   int n_pass   = 0;
   int n_checks = 0;

   uart_tx_parity #(.CLK_HZ(38400), .BAUD(9600)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .parity  (parity),
      .send    (send),
      .tdre    (tdre),
      .busy    (busy),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic p);
      logic pb;
      pb = (^b) ^ p;
      return {1'b1, pb, b, 1'b0};
   endfunction

   // Line model: a frame is just an 11-bit vector played out for FRAME_CLKS cycles.
   logic        m_active = 1'b0;
   logic        m_hold_v = 1'b0;
   logic        m_hold_p = 1'b0;
   logic        m_acc    = 1'b0;
   logic [7:0]  m_hold_b = 8'h00;
   logic [10:0] m_bits   = 11'h7FF;
   int          m_pos    = 0;
   int          n_accepted = 0;
   logic [8:0]  exp_q[$];

   task automatic model_start();
      m_bits   = frame_bits(m_hold_b, m_hold_p);
      exp_q.push_back({m_hold_p, m_hold_b});
      m_active = 1'b1;
      m_pos    = 0;
      m_hold_v = 1'b0;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 1'b0;
         m_hold_v = 1'b0;
         m_pos    = 0;
         exp_q.delete();
      end else begin
         m_acc = send && !m_hold_v;
         if (m_active) begin
            m_pos++;
            if (m_pos == FRAME_CLKS) begin
               if (m_hold_v) model_start();
               else m_active = 1'b0;
            end
         end else if (m_hold_v) begin
            model_start();
         end
         if (m_acc) begin
            m_hold_v = 1'b1;
            m_hold_b = tx_data;
            m_hold_p = parity;
            n_accepted++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      check("tx", tx, m_active ? m_bits[m_pos / DIV] : 1'b1);
      check("busy", busy, m_active);
      check("tdre", tdre, !m_hold_v);
   end

   // Reference receiver: detects the start edge and samples each bit mid-period.
   logic        r_active = 1'b0;
   int          r_cnt    = 0;
   logic [10:0] r_bits   = 11'h7FF;
   logic [8:0]  r_exp;
   int          rx_count = 0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         r_active = 1'b0;
      end else if (!r_active) begin
         if (tx == 1'b0) begin
            r_active = 1'b1;
            r_cnt    = 0;
         end
      end else begin
         r_cnt++;
      end
      if (r_active && (r_cnt % DIV) == DIV / 2) r_bits[r_cnt / DIV] = tx;
      if (r_active && r_cnt == 10 * DIV + DIV / 2) begin
         check("rx_expected_frame", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            r_exp = exp_q.pop_front();
            check("rx_start", r_bits[0], 1'b0);
            check("rx_data", r_bits[8:1], r_exp[7:0]);
            check("rx_parity", r_bits[9], (^r_exp[7:0]) ^ r_exp[8]);
            check("rx_stop", r_bits[10], 1'b1);
         end
         rx_count++;
         r_active = 1'b0;
      end
   end

   task automatic pulse_send(input logic [7:0] b, input logic p);
      send    = 1'b1;
      tx_data = b;
      parity  = p;
      @(negedge clk);
      send = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] b, input logic p, output logic [10:0] cap, output int nbusy);
      pulse_send(b, p);
      check("tdre_after_load", tdre, 1'b0);
      @(negedge clk);
      check("tx_start_latency", tx, 1'b0);
      check("tdre_after_start", tdre, 1'b1);
      nbusy = 0;
      cap   = 11'h7FF;
      while (busy && nbusy < 100) begin
         if (nbusy < FRAME_CLKS && (nbusy % DIV) == DIV / 2) cap[nbusy / DIV] = tx;
         nbusy++;
         @(negedge clk);
      end
   endtask

   logic [10:0] cap;
   int          nb;
   int          falls;
   int          nlow;
   int          rx0;
   int          acc0;
   int          cyc;
   logic        prev;

   initial begin
      check("model_frame_55", frame_bits(8'h55, 1'b0), 11'h4AA);
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_tdre", tdre, 1'b1);

      rst_n = 1'b1;
      run_frame(8'h55, 1'b0, cap, nb);
      check("frame_55", cap, 11'h4AA);
      check("busy_clks_55", nb, 44);

      run_frame(8'h01, 1'b1, cap, nb);
      check("par_01_odd", cap[9], 1'b0);
      run_frame(8'h03, 1'b1, cap, nb);
      check("par_03_odd", cap[9], 1'b1);

      repeat (3) @(negedge clk);
      rx0 = rx_count;
      pulse_send(8'hA5, 1'b0);
      nb    = 0;
      falls = 0;
      prev  = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (busy) nb++;
         if (prev && !busy) falls++;
         prev = busy;
         if (i == 44) check("tdre_held_b2b", tdre, 1'b0);
         if (i == 45) check("tdre_free_b2b", tdre, 1'b1);
         if (i == 9) begin
            send = 1'b1; tx_data = 8'h3C; parity = 1'b1;
         end else if (i == 10) begin
            send = 1'b1; tx_data = 8'hFF; parity = 1'b0;
         end else begin
            send = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b_busy_clks", nb, 88);
      check("b2b_busy_falls", falls, 1);
      check("b2b_rx_frames", rx_count - rx0, 2);

      rx0 = rx_count;
      pulse_send(8'h96, 1'b1);
      @(negedge clk);
      pulse_send(8'h11, 1'b0);
      repeat (18) @(negedge clk);
      check("pre_reset_tx", tx, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_tx", tx, 1'b1);
      check("rst_async_busy", busy, 1'b0);
      check("rst_async_tdre", tdre, 1'b1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      nlow = 0;
      nb   = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!tx) nlow++;
         if (busy) nb++;
      end
      check("post_reset_tx_low_clks", nlow, 0);
      check("post_reset_busy_clks", nb, 0);
      check("post_reset_rx_frames", rx_count - rx0, 0);

      acc0 = n_accepted;
      rx0  = rx_count;
      cyc  = 0;
      while ((n_accepted - acc0) < 256 && cyc < 30000) begin
         send    = ($urandom_range(0, 5) == 0);
         tx_data = 8'($urandom);
         parity  = 1'($urandom);
         @(negedge clk);
         cyc++;
      end
      send = 1'b0;
      check("rand_accept_budget", n_accepted - acc0, 256);
      cyc = 0;
      while ((busy || !tdre) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      repeat (4) @(negedge clk);
      check("rand_drain_budget", cyc < 200, 1'b1);
      check("rand_rx_frames", rx_count - rx0, 256);
      check("rand_queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_parity.md
UART_TX_PARITY -- requirements
Module: uart_tx_parity

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 24000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning line bit rate.
REQ-003 The block SHALL have derived constant DIV = CLK_HZ/BAUD (integer division), meaning clocks per bit; DIV>=2 is required.
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port tx_data  input  8  byte to transmit, sampled when send is accepted.
REQ-007 The block SHALL have port parity  input  1  parity select (0 = even, 1 = odd), sampled with tx_data.
REQ-008 The block SHALL have port send  input  1  single-cycle load request.
REQ-009 The block SHALL have port tdre  output  1  transmit data register empty (holding register free).
REQ-010 The block SHALL have port busy  output  1  high while a frame is on the line.
REQ-011 The block SHALL have port tx  output  1  serial line; idle high; registered output.

Function
REQ-012 Frame format SHALL be: start (0), 8 data bits LSB first, parity bit, stop (1); 11 bits total, each exactly DIV clocks.
REQ-013 Parity bit SHALL be XOR of the 8 data bits when parity=0, and its inverse when parity=1.
REQ-014 send with tdre=1 at edge k SHALL write tx_data/parity into the holding register and drive tdre=0 after edge k.
REQ-015 send with tdre=0 SHALL be ignored; holding-register contents and the frame in flight SHALL be unchanged.
REQ-016 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-017 IDLE with holding full at edge k+1 SHALL move holding to shift register, set tdre=1, enter START, drive tx=0 and busy=1 after that edge (send-to-start latency 2 clocks).
REQ-018 START->DATA, DATA->PAR after the 8th bit (bit counter 0..7), PAR->STOP SHALL each occur when the baud counter reaches DIV-1.
REQ-019 At the last clock of STOP, holding full SHALL transition directly to START with the next byte (no idle gap); holding empty SHALL go to IDLE with busy=0.
REQ-020 Baud counter SHALL reset to 0 on every state entry and count 0..DIV-1 without skipping.
REQ-021 The holding register SHALL be refillable during a frame, giving one byte of buffering; tdre goes high at the edge the shift register loads.
REQ-022 tx SHALL never glitch: it changes only on bit boundaries.

Reset
REQ-023 While rst_n=0, outputs SHALL be tx=1, tdre=1, busy=0, state IDLE, counters 0, holding empty, asynchronously and independent of clk.
REQ-024 Reset mid-frame SHALL abort the frame immediately (tx=1); the buffered byte SHALL be discarded; no partial frame resumes after release.
REQ-025 The first send SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enumeration, parity encoding constants (PAR_EVEN=0, PAR_ODD=1) and the DIV computation.
REQ-027 Baud timing SHALL be one sub-module, uart_baud_gen (counter with clear input and terminal-count output), shared later with the receiver.
REQ-028 The rest (FSM, holding register, shift register, bit counter) SHALL live in uart_tx_parity.

Verification (bench uses DIV=4, frame = 44 clocks)
REQ-029 Reset, then send 0x55 with parity=0 -> tx=0 starting 2 clocks after send, then 1,0,1,0,1,0,1,0, parity 0, stop 1, each 4 clocks; busy falls after 44 clocks.
REQ-030 Send 0x01 with parity=1 -> parity bit 0; send 0x03 with parity=1 -> parity bit 1.
REQ-031 Send 0xA5, then send 0x3C 10 clocks later -> tdre=0 until second frame start; 0x3C start bit immediately follows 0xA5 stop bit; 88 continuous busy clocks.
REQ-032 With buffer full, send 0xFF -> ignored; line carries only the two earlier bytes.
REQ-033 Assert rst_n=0 at clock 20 of a frame -> tx=1, busy=0, tdre=1 within the same cycle; after release, tx stays 1 until a new send.
REQ-034 A line-side reference receiver (8-bit, parity checked) SHALL decode 256 random bytes with random parity, with zero data or parity errors.
